// File: rtl/uart_rx_pkg.sv
// ============================================================================
//  Module      : uart_rx_pkg
//  Description : Shared types and constants for the UART RX frame checker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int STK_STRT = 0;
    localparam int STK_PAR  = 1;
    localparam int STK_STP  = 2;

    // Even parity expects the running XOR itself, odd parity its complement.
    function automatic logic expected_parity(input logic acc, input logic par_type);
        logic result;
        result = (par_type == PAR_ODD) ? ~acc : acc;
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_err_stats.sv
// ============================================================================
//  Module      : uart_err_stats
//  Description : Sticky error flags and saturating good/bad frame counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_err_stats
    import uart_rx_pkg::*;
#(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 err_clr,
    input  logic                 strt_evt,
    input  logic                 par_evt,
    input  logic                 stp_evt,
    input  logic                 ok_evt,
    input  logic                 err_evt,
    output logic [2:0]           err_sticky,
    output logic [CNT_WIDTH-1:0] ok_cnt,
    output logic [CNT_WIDTH-1:0] err_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [2:0]           sticky_q, sticky_d;
    logic [CNT_WIDTH-1:0] ok_cnt_q, ok_cnt_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    // A new event beats a simultaneous clear: the clear is applied first.
    function automatic logic [CNT_WIDTH-1:0] cnt_next(
        input logic [CNT_WIDTH-1:0] cur,
        input logic                 evt,
        input logic                 clr
    );
        logic [CNT_WIDTH-1:0] result;
        if (evt) begin
            if (clr)
                result = CNT_ONE;
            else if (cur == CNT_MAX)
                result = cur;
            else
                result = cur + CNT_ONE;
        end else if (clr) begin
            result = '0;
        end else begin
            result = cur;
        end
        return result;
    endfunction

    always_comb begin
        sticky_d           = sticky_q;
        sticky_d[STK_STRT] = strt_evt | (sticky_q[STK_STRT] & ~err_clr);
        sticky_d[STK_PAR]  = par_evt  | (sticky_q[STK_PAR]  & ~err_clr);
        sticky_d[STK_STP]  = stp_evt  | (sticky_q[STK_STP]  & ~err_clr);
        ok_cnt_d           = cnt_next(ok_cnt_q, ok_evt, err_clr);
        err_cnt_d          = cnt_next(err_cnt_q, err_evt, err_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky_q  <= '0;
            ok_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            sticky_q  <= sticky_d;
            ok_cnt_q  <= ok_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_sticky = sticky_q;
    assign ok_cnt     = ok_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule

`default_nettype wire

// File: rtl/uart_frame_check.sv
// ============================================================================
//  Module      : uart_frame_check
//  Description : UART RX frame checker: start/data/parity/stop tracking,
//                data assembly, error pulses and statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_frame_check
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  sample_valid,
    input  logic                  sampled_bit,
    input  logic                  par_en,
    input  logic                  par_type,
    input  logic                  stop2,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  frame_done,
    output logic                  strt_glitch,
    output logic                  par_err,
    output logic                  stp_err,
    output logic [2:0]            err_sticky,
    output logic [CNT_WIDTH-1:0]  ok_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    localparam int             BW       = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0]  BIT_ONE  = BW'(1);

    rx_state_e             state_q, state_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  acc_q, acc_d;
    logic                  ferr_q, ferr_d;
    logic                  stop_idx_q, stop_idx_d;
    logic                  par_en_q, par_en_d;
    logic                  par_type_q, par_type_d;
    logic                  stop2_q, stop2_d;
    logic                  data_valid_q, data_valid_d;
    logic                  frame_done_q, frame_done_d;
    logic                  strt_glitch_q, strt_glitch_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic                  ok_evt, err_evt;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        data_out_d    = data_out_q;
        acc_d         = acc_q;
        ferr_d        = ferr_q;
        stop_idx_d    = stop_idx_q;
        par_en_d      = par_en_q;
        par_type_d    = par_type_q;
        stop2_d       = stop2_q;
        data_valid_d  = 1'b0;
        frame_done_d  = 1'b0;
        strt_glitch_d = 1'b0;
        par_err_d     = 1'b0;
        stp_err_d     = 1'b0;
        ok_evt        = 1'b0;
        err_evt       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Frame configuration is frozen here for the whole frame.
                if (frame_start) begin
                    par_en_d   = par_en;
                    par_type_d = par_type;
                    stop2_d    = stop2;
                    acc_d      = 1'b0;
                    ferr_d     = 1'b0;
                    state_d    = ST_START;
                end
            end

            ST_START: begin
                if (sample_valid) begin
                    if (sampled_bit) begin
                        strt_glitch_d = 1'b1;
                        err_evt       = 1'b1;
                        state_d       = ST_IDLE;
                    end else begin
                        bit_cnt_d = '0;
                        state_d   = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (sample_valid) begin
                    shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    acc_d   = acc_q ^ sampled_bit;
                    if (bit_cnt_q == BIT_LAST) begin
                        stop_idx_d = 1'b0;
                        state_d    = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end
            end

            ST_PARITY: begin
                if (sample_valid) begin
                    if (sampled_bit != expected_parity(acc_q, par_type_q)) begin
                        par_err_d = 1'b1;
                        ferr_d    = 1'b1;
                    end
                    stop_idx_d = 1'b0;
                    state_d    = ST_STOP;
                end
            end

            ST_STOP: begin
                if (sample_valid) begin
                    if (!sampled_bit) begin
                        stp_err_d = 1'b1;
                        ferr_d    = 1'b1;
                    end
                    if (stop2_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        state_d      = ST_IDLE;
                        frame_done_d = 1'b1;
                        // ferr_q misses an error on this very stop bit, so check it too.
                        if (ferr_q || !sampled_bit) begin
                            err_evt = 1'b1;
                        end else begin
                            data_valid_d = 1'b1;
                            data_out_d   = shift_q;
                            ok_evt       = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            data_out_q    <= '0;
            acc_q         <= 1'b0;
            ferr_q        <= 1'b0;
            stop_idx_q    <= 1'b0;
            par_en_q      <= 1'b0;
            par_type_q    <= 1'b0;
            stop2_q       <= 1'b0;
            data_valid_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            strt_glitch_q <= 1'b0;
            par_err_q     <= 1'b0;
            stp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            data_out_q    <= data_out_d;
            acc_q         <= acc_d;
            ferr_q        <= ferr_d;
            stop_idx_q    <= stop_idx_d;
            par_en_q      <= par_en_d;
            par_type_q    <= par_type_d;
            stop2_q       <= stop2_d;
            data_valid_q  <= data_valid_d;
            frame_done_q  <= frame_done_d;
            strt_glitch_q <= strt_glitch_d;
            par_err_q     <= par_err_d;
            stp_err_q     <= stp_err_d;
        end
    end

    uart_err_stats #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_stats (
        .clk        (clk),
        .rst        (rst),
        .err_clr    (err_clr),
        .strt_evt   (strt_glitch_d),
        .par_evt    (par_err_d),
        .stp_evt    (stp_err_d),
        .ok_evt     (ok_evt),
        .err_evt    (err_evt),
        .err_sticky (err_sticky),
        .ok_cnt     (ok_cnt),
        .err_cnt    (err_cnt)
    );

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign frame_done  = frame_done_q;
    assign strt_glitch = strt_glitch_q;
    assign par_err     = par_err_q;
    assign stp_err     = stp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_check.sv
// ============================================================================
//  Module      : tb_uart_frame_check
//  Description : Randomised scoreboard bench for uart_frame_check.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_frame_check;

    localparam int DW       = 8;
    localparam int CW       = 8;
    localparam int CMAX_INT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          frame_start = 1'b0;
    logic          sample_valid = 1'b0;
    logic          sampled_bit = 1'b1;
    logic          par_en = 1'b0;
    logic          par_type = 1'b0;
    logic          stop2 = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_valid, frame_done, strt_glitch, par_err, stp_err;
    logic [2:0]    err_sticky;
    logic [CW-1:0] ok_cnt, err_cnt;

    uart_frame_check #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .sample_valid (sample_valid),
        .sampled_bit  (sampled_bit),
        .par_en       (par_en),
        .par_type     (par_type),
        .stop2        (stop2),
        .err_clr      (err_clr),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .frame_done   (frame_done),
        .strt_glitch  (strt_glitch),
        .par_err      (par_err),
        .stp_err      (stp_err),
        .err_sticky   (err_sticky),
        .ok_cnt       (ok_cnt),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit glitch;
        bit dv;
        int par_n;
        int stp_n;
        int data;
        int ok;
        int err;
        int sticky;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    // Reference state: what the register interface should show.
    int m_data = 0;
    int m_ok = 0;
    int m_err = 0;
    int m_sticky = 0;

    function automatic int sat(input int v);
        return (v >= CMAX_INT) ? CMAX_INT : v + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: counts error pulses within a frame and checks each frame end.
    int par_seen = 0;
    int stp_seen = 0;
    always @(negedge clk) begin
        if (!rst) begin
            par_seen = 0;
            stp_seen = 0;
        end else begin
            if (par_err) par_seen++;
            if (stp_err) stp_seen++;
            if (data_valid && !frame_done) chk("dv_without_done", 32'(data_valid), 32'(0));
            if (frame_done || strt_glitch) begin
                if (q.size() == 0) begin
                    chk("unexpected_frame_end", 32'(1), 32'(0));
                end else begin
                    mon_e = q.pop_front();
                    chk("strt_glitch", 32'(strt_glitch), 32'(mon_e.glitch));
                    chk("frame_done", 32'(frame_done), 32'(!mon_e.glitch));
                    chk("data_valid", 32'(data_valid), 32'(mon_e.dv));
                    chk("par_err_pulses", 32'(par_seen), 32'(mon_e.par_n));
                    chk("stp_err_pulses", 32'(stp_seen), 32'(mon_e.stp_n));
                    chk("data_out", 32'(data_out), 32'(mon_e.data));
                    chk("ok_cnt", 32'(ok_cnt), 32'(mon_e.ok));
                    chk("err_cnt", 32'(err_cnt), 32'(mon_e.err));
                    chk("err_sticky", 32'(err_sticky), 32'(mon_e.sticky));
                end
                par_seen = 0;
                stp_seen = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 3)) tick();
    endtask

    task automatic cfg_noise();
        par_en   = 1'($urandom);
        par_type = 1'($urandom);
        stop2    = 1'($urandom);
    endtask

    task automatic sample(input logic b, input logic fs_noise);
        sample_valid = 1'b1;
        sampled_bit  = b;
        frame_start  = fs_noise;
        tick();
        sample_valid = 1'b0;
        frame_start  = 1'b0;
        sampled_bit  = 1'($urandom);
    endtask

    task automatic begin_frame(input logic pe, input logic pt, input logic s2);
        // A stray sample strobe while idle must be ignored.
        if ($urandom_range(0, 1) == 1) begin
            sample_valid = 1'b1;
            sampled_bit  = 1'b0;
            tick();
            sample_valid = 1'b0;
        end
        par_en      = pe;
        par_type    = pt;
        stop2       = s2;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_glitch();
        exp_t e;
        begin_frame(1'($urandom), 1'($urandom), 1'($urandom));
        gap();
        m_err     = sat(m_err);
        m_sticky |= 1;
        e = '{glitch: 1'b1, dv: 1'b0, par_n: 0, stp_n: 0, data: m_data,
              ok: m_ok, err: m_err, sticky: m_sticky};
        q.push_back(e);
        sample(1'b1, 1'b0);
    endtask

    task automatic send_frame(input logic [DW-1:0] data, input logic pe, input logic pt,
                              input logic s2, input logic flip, input logic st0,
                              input logic st1, input logic clr_last);
        bit   bits[$];
        exp_t e;
        logic pbit;
        int   n_stp;
        bit   perr, bad, last_low;
        pbit     = (pt ? ~(^data) : (^data)) ^ flip;
        perr     = pe && flip;
        n_stp    = (st0 ? 0 : 1) + ((s2 && !st1) ? 1 : 0);
        bad      = perr || (n_stp != 0);
        last_low = s2 ? !st1 : !st0;
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(data[i]);
        if (pe) bits.push_back(pbit);
        bits.push_back(st0);
        if (s2) bits.push_back(st1);

        begin_frame(pe, pt, s2);
        for (int i = 0; i < bits.size(); i++) begin
            gap();
            cfg_noise();
            if (i == bits.size() - 1) begin
                if (clr_last) begin
                    err_clr  = 1'b1;
                    m_ok     = 0;
                    m_err    = 0;
                    m_sticky = last_low ? 4 : 0;
                end else begin
                    m_sticky |= (perr ? 2 : 0) | ((n_stp != 0) ? 4 : 0);
                end
                if (bad) m_err = sat(m_err);
                else begin
                    m_ok   = sat(m_ok);
                    m_data = int'(data);
                end
                e = '{glitch: 1'b0, dv: !bad, par_n: perr ? 1 : 0, stp_n: n_stp,
                      data: m_data, ok: m_ok, err: m_err, sticky: m_sticky};
                q.push_back(e);
                sample(bits[i], 1'b0);
                err_clr = 1'b0;
            end else begin
                sample(bits[i], 1'($urandom));
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_data_out"}, 32'(data_out), 32'(0));
        chk({tag, "_pulses"}, 32'({data_valid, frame_done, strt_glitch, par_err, stp_err}), 32'(0));
        chk({tag, "_sticky"}, 32'(err_sticky), 32'(0));
        chk({tag, "_ok_cnt"}, 32'(ok_cnt), 32'(0));
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rb;
        logic          ps0, ps1;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_glitch();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        send_frame(8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                send_glitch();
            end else begin
                rb  = DW'($urandom);
                ps0 = ($urandom_range(0, 5) != 0);
                ps1 = ($urandom_range(0, 5) != 0);
                send_frame(rb, 1'($urandom), 1'($urandom), 1'($urandom),
                           ($urandom_range(0, 4) == 0), ps0, ps1, 1'b0);
            end
        end

        // Drive the error counter into saturation and one beyond.
        while (m_err < CMAX_INT) send_glitch();
        send_glitch();
        send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Abort a frame during data bit 4.
        repeat (20) tick();
        rb = 8'hFF;
        begin_frame(1'b0, 1'b0, 1'b0);
        sample(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) sample(rb[i], 1'b0);
        rst = 1'b0;
        #1;
        check_all_zero("abort");
        m_data = 0;
        m_ok = 0;
        m_err = 0;
        m_sticky = 0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        for (int w = 0; w < 50 && q.size() != 0; w++) tick();
        repeat (3) tick();
        chk("scoreboard_drained", 32'(q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
